nanorv32_csr_access: RTL and testbench
======================================

Name: nanorv32_csr_access

Overview:
Initiator side of the core-to-CSR interface. Sits in the execute stage and turns decoded CSRRW/CSRRS/CSRRC (and immediate forms) into a sequenced read-modify-write on the CSR file bus (core_csr_addr/core_csr_wdata/core_csr_write in, csr_core_rdata out). Stalls the pipeline while the access runs and returns the old CSR value for rd writeback.

Parameters:
CSR_ADDR_W, 12, CSR address width; equals NANORV32_CSR_ADDR_MSB+1.
DATA_W, 32, data width; equals NANORV32_DATA_MSB+1.

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
exe_csr_valid  input  1  CSR instruction present in execute; held until csr_done
exe_csr_op  input  2  01=RW, 10=RS (set), 11=RC (clear); 00 reserved/illegal
exe_csr_addr  input  CSR_ADDR_W  target CSR
exe_csr_src  input  DATA_W  rs1 value or zero-extended zimm
exe_csr_src_is_zero_reg  input  1  rs1 field (or zimm) is 0
exe_flush  input  1  squash the current instruction (trap/branch)
core_csr_addr  output  CSR_ADDR_W  CSR bus address
core_csr_wdata  output  DATA_W  CSR bus write data
core_csr_write  output  1  CSR bus write strobe, one cycle
csr_core_rdata  input  DATA_W  CSR bus read data, combinational from core_csr_addr
csr_stall  output  1  hold execute stage
csr_done  output  1  one-cycle completion pulse
csr_rd_wdata  output  DATA_W  old CSR value for rd
csr_rd_we  output  1  rd write enable, coincident with csr_done
csr_illegal  output  1  one-cycle illegal-access pulse, coincident with csr_done

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; all outputs 0; internal rdata/src registers 0.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: csr_stall = exe_csr_valid (combinational). When exe_csr_valid && !exe_flush, latch addr/op/src/zero flag -> READ.
- READ: drive core_csr_addr = latched addr. Capture csr_core_rdata into old_r. Compute new = RW: src; RS: old|src; RC: old&~src. Write suppressed when op in {RS,RC} && src_is_zero_reg. Next state is WRITE if the write is needed and legal, else DONE. csr_stall=1.
- WRITE: core_csr_write=1 for exactly this cycle, core_csr_wdata=new_r, address held. Next state DONE. csr_stall=1.
- DONE: csr_done=1, csr_rd_we=!illegal, csr_rd_wdata=old_r, csr_stall=0. Next state IDLE. A new exe_csr_valid is not accepted in the DONE cycle.
- Latency: with a write, valid to done is 3 cycles (READ, WRITE, DONE). Without a write, it is 2 cycles.
- At most one core_csr_write per instruction. core_csr_write is never asserted outside WRITE.
- op=00: illegal. No write, csr_illegal=1 in DONE, csr_rd_we=0.
- exe_flush in READ: abort to IDLE, no write, no done. exe_flush in WRITE: ignored, because the write commits; DONE still pulses. exe_flush in DONE: csr_rd_we forced 0.
- rst asserted mid-operation: immediate return to IDLE on that edge. Any pending write is dropped.
- core_csr_addr and core_csr_wdata are 0 in IDLE. This keeps the bus quiet.

Optional Feature:
NANORV32_CSR_RO_CHECK_EN.
- Defined: a write attempt to addr[11:10]==2'b11 (read-only space, e.g. cycle/time/instret) skips WRITE. The result is csr_illegal=1 and csr_rd_we=0 in DONE.
- RS/RC with src_is_zero_reg to a read-only CSR stays legal. This is a pure read.
- Undefined: no check. The write strobe is issued, the CSR file ignores it, csr_illegal fires only for op=00.

Decomposition:
- nanorv32_parameters (shared): NANORV32_CSR_OP_RW/RS/RC encodings, FSM state encodings, NANORV32_CSR_ADDR_MSB, NANORV32_DATA_MSB.
- Sub-module nanorv32_csr_alu (combinational): op, old, src -> new, write_needed.

Test Plan:
1. CSRRW addr 0x340, src 0xDEADBEEF, CSR holds 0x12345678: write strobe with 0xDEADBEEF in cycle 2. done in cycle 3 with rd=0x12345678. Stall 1,1,0.
2. CSRRS src 0x0000_00F0 on 0x0000_000F: wdata 0x0000_00FF. Same CSRRS with src_is_zero_reg=1: no write strobe, done in 2 cycles, rd=0x0000_000F.
3. CSRRC src 0x0000_0003 on 0xFFFF_FFFF: wdata 0xFFFF_FFFC, rd=0xFFFF_FFFF.
4. exe_flush in READ cycle: no core_csr_write, no csr_done, next valid accepted the following cycle. Flush in WRITE: write 1 cycle, done=1, rd_we=1.
5. With NANORV32_CSR_RO_CHECK_EN: CSRRW to 0xC00 (cycle) -> no write, csr_illegal=1, rd_we=0. CSRRS x0 to 0xC02 -> rd = instret low, no illegal.
6. rst=1 while in WRITE: next cycle core_csr_write=0, state IDLE, all outputs 0. Back-to-back instructions complete with one idle (DONE) gap.

Source files
------------

// File: rtl/nanorv32_parameters.sv
// Shared encodings and widths for the nanorv32 CSR access path.
// CSR op encodings, FSM state encoding and bus width constants.
package nanorv32_parameters;

    localparam int NANORV32_CSR_ADDR_MSB = 11;
    localparam int NANORV32_DATA_MSB     = 31;

    localparam logic [1:0] NANORV32_CSR_OP_ILL = 2'b00;
    localparam logic [1:0] NANORV32_CSR_OP_RW  = 2'b01;
    localparam logic [1:0] NANORV32_CSR_OP_RS  = 2'b10;
    localparam logic [1:0] NANORV32_CSR_OP_RC  = 2'b11;

    typedef enum logic [1:0] {
        NANORV32_ST_IDLE  = 2'b00,
        NANORV32_ST_READ  = 2'b01,
        NANORV32_ST_WRITE = 2'b10,
        NANORV32_ST_DONE  = 2'b11
    } csr_state_e;

endpackage

// File: rtl/nanorv32_csr_alu.sv
// Combinational read-modify-write datapath for CSRRW/CSRRS/CSRRC.
// Yields the new CSR value and whether a bus write is needed at all.
module nanorv32_csr_alu
    import nanorv32_parameters::*;
#(
    parameter int DATA_W = NANORV32_DATA_MSB + 1
) (
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] src_i,
    input  logic              src_zero_i,
    output logic [DATA_W-1:0] new_o,
    output logic              write_needed_o
);

    always_comb begin
        new_o          = old_i;
        write_needed_o = 1'b0;
        case (op_i)
            NANORV32_CSR_OP_RW: begin
                new_o          = src_i;
                write_needed_o = 1'b1;
            end
            NANORV32_CSR_OP_RS: begin
                new_o          = old_i | src_i;
                write_needed_o = !src_zero_i;
            end
            NANORV32_CSR_OP_RC: begin
                new_o          = old_i & ~src_i;
                write_needed_o = !src_zero_i;
            end
            default: begin
                new_o          = old_i;
                write_needed_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/nanorv32_csr_access.sv
// Execute-stage CSR initiator: sequences read / write / done on the CSR bus.
// Define NANORV32_CSR_RO_CHECK_EN to trap writes to the read-only CSR space.
module nanorv32_csr_access
    import nanorv32_parameters::*;
#(
    parameter int CSR_ADDR_W = NANORV32_CSR_ADDR_MSB + 1,
    parameter int DATA_W     = NANORV32_DATA_MSB + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exe_csr_valid,
    input  logic [1:0]            exe_csr_op,
    input  logic [CSR_ADDR_W-1:0] exe_csr_addr,
    input  logic [DATA_W-1:0]     exe_csr_src,
    input  logic                  exe_csr_src_is_zero_reg,
    input  logic                  exe_flush,
    output logic [CSR_ADDR_W-1:0] core_csr_addr,
    output logic [DATA_W-1:0]     core_csr_wdata,
    output logic                  core_csr_write,
    input  logic [DATA_W-1:0]     csr_core_rdata,
    output logic                  csr_stall,
    output logic                  csr_done,
    output logic [DATA_W-1:0]     csr_rd_wdata,
    output logic                  csr_rd_we,
    output logic                  csr_illegal
);

    csr_state_e state_q, state_d;

    logic [CSR_ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_W-1:0]     src_q, src_d;
    logic                  zero_q, zero_d;
    logic [DATA_W-1:0]     old_q, old_d;
    logic [DATA_W-1:0]     new_q, new_d;
    logic                  ill_q, ill_d;

    logic [DATA_W-1:0]     alu_new;
    logic                  alu_wr;
    logic                  ro_viol;
    logic                  wr_go;
    logic                  accept;

    nanorv32_csr_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op_i          (op_q),
        .old_i         (csr_core_rdata),
        .src_i         (src_q),
        .src_zero_i    (zero_q),
        .new_o         (alu_new),
        .write_needed_o(alu_wr)
    );

`ifdef NANORV32_CSR_RO_CHECK_EN
    // Pure reads (RS/RC with x0) of read-only CSRs stay legal.
    assign ro_viol = alu_wr && (addr_q[CSR_ADDR_W-1 -: 2] == 2'b11);
`else
    assign ro_viol = 1'b0;
`endif

    assign wr_go  = alu_wr && !ro_viol;
    assign accept = exe_csr_valid && !exe_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NANORV32_ST_IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            src_q   <= '0;
            zero_q  <= 1'b0;
            old_q   <= '0;
            new_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            src_q   <= src_d;
            zero_q  <= zero_d;
            old_q   <= old_d;
            new_q   <= new_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NANORV32_ST_IDLE: begin
                if (accept) state_d = NANORV32_ST_READ;
            end
            NANORV32_ST_READ: begin
                if (exe_flush)  state_d = NANORV32_ST_IDLE;
                else if (wr_go) state_d = NANORV32_ST_WRITE;
                else            state_d = NANORV32_ST_DONE;
            end
            NANORV32_ST_WRITE: state_d = NANORV32_ST_DONE;
            NANORV32_ST_DONE:  state_d = NANORV32_ST_IDLE;
            default:           state_d = NANORV32_ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        op_d   = op_q;
        src_d  = src_q;
        zero_d = zero_q;
        old_d  = old_q;
        new_d  = new_q;
        ill_d  = ill_q;
        if (state_q == NANORV32_ST_IDLE && accept) begin
            addr_d = exe_csr_addr;
            op_d   = exe_csr_op;
            src_d  = exe_csr_src;
            zero_d = exe_csr_src_is_zero_reg;
        end
        if (state_q == NANORV32_ST_READ) begin
            old_d = csr_core_rdata;
            new_d = alu_new;
            ill_d = (op_q == NANORV32_CSR_OP_ILL) || ro_viol;
        end
    end

    always_comb begin
        core_csr_addr  = '0;
        core_csr_wdata = '0;
        core_csr_write = 1'b0;
        csr_stall      = 1'b0;
        csr_done       = 1'b0;
        csr_rd_wdata   = '0;
        csr_rd_we      = 1'b0;
        csr_illegal    = 1'b0;
        unique case (state_q)
            NANORV32_ST_IDLE: begin
                csr_stall = exe_csr_valid;
            end
            NANORV32_ST_READ: begin
                core_csr_addr = addr_q;
                csr_stall     = 1'b1;
            end
            NANORV32_ST_WRITE: begin
                core_csr_addr  = addr_q;
                core_csr_wdata = new_q;
                core_csr_write = 1'b1;
                csr_stall      = 1'b1;
            end
            NANORV32_ST_DONE: begin
                csr_done     = 1'b1;
                csr_rd_wdata = old_q;
                csr_rd_we    = !ill_q && !exe_flush;
                csr_illegal  = ill_q;
            end
            default: begin
                csr_stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_nanorv32_csr_access.sv
// Scoreboard bench for nanorv32_csr_access: directed CSR vectors.
// Honours NANORV32_CSR_RO_CHECK_EN when the RTL is built with it.
module tb_nanorv32_csr_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exe_csr_valid = 1'b0;
    logic [1:0]  exe_csr_op = 2'b00;
    logic [11:0] exe_csr_addr = '0;
    logic [31:0] exe_csr_src = '0;
    logic        exe_csr_src_is_zero_reg = 1'b0;
    logic        exe_flush = 1'b0;
    logic [11:0] core_csr_addr;
    logic [31:0] core_csr_wdata;
    logic        core_csr_write;
    logic [31:0] csr_core_rdata;
    logic        csr_stall;
    logic        csr_done;
    logic [31:0] csr_rd_wdata;
    logic        csr_rd_we;
    logic        csr_illegal;

    logic [31:0] mem [4096];

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        we;
        logic        ill;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int  n_vec = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    assign csr_core_rdata = mem[core_csr_addr];

    nanorv32_csr_access dut (
        .clk                    (clk),
        .rst                    (rst),
        .exe_csr_valid          (exe_csr_valid),
        .exe_csr_op             (exe_csr_op),
        .exe_csr_addr           (exe_csr_addr),
        .exe_csr_src            (exe_csr_src),
        .exe_csr_src_is_zero_reg(exe_csr_src_is_zero_reg),
        .exe_flush              (exe_flush),
        .core_csr_addr          (core_csr_addr),
        .core_csr_wdata         (core_csr_wdata),
        .core_csr_write         (core_csr_write),
        .csr_core_rdata         (csr_core_rdata),
        .csr_stall              (csr_stall),
        .csr_done               (csr_done),
        .csr_rd_wdata           (csr_rd_wdata),
        .csr_rd_we              (csr_rd_we),
        .csr_illegal            (csr_illegal)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t w;
        dn_t d;
        forever begin
            @(negedge clk);
            if (core_csr_write) begin
                if (wq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %h data %h want none",
                             core_csr_addr, core_csr_wdata);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", 64'(core_csr_addr), 64'(w.a));
                    chk("wr_data", 64'(core_csr_wdata), 64'(w.d));
                end
            end
            if (csr_done) begin
                if (dq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got rd %h want none", csr_rd_wdata);
                end else begin
                    d = dq.pop_front();
                    chk("rd_wdata", 64'(csr_rd_wdata), 64'(d.rd));
                    chk("rd_we", 64'(csr_rd_we), 64'(d.we));
                    chk("illegal", 64'(csr_illegal), 64'(d.ill));
                end
            end else begin
                chk("pulse_outside_done", 64'({csr_rd_we, csr_illegal}), 64'd0);
            end
        end
    endtask

    // Called in an IDLE cycle just after a rising edge.
    task automatic run(input string nm, input logic [1:0] op,
                       input logic [11:0] a, input logic [31:0] src,
                       input logic z, input logic [31:0] old,
                       input int fa, input int ra,
                       input bit ew, input logic [31:0] ewd,
                       input bit ed, input logic [31:0] erd,
                       input logic ewe, input logic eill, input int elat);
        int  kill;
        int  lat;
        int  cmax;
        bit  seen;
        kill = ed ? 0 : ((fa > 0) ? fa : ra);
        cmax = ed ? elat + 3 : kill + 1;
        lat  = 0;
        seen = 1'b0;
        mem[a] = old;
        if (ew) wq.push_back('{a, ewd});
        if (ed) dq.push_back('{erd, ewe, eill});
        exe_csr_valid           = 1'b1;
        exe_csr_op              = op;
        exe_csr_addr            = a;
        exe_csr_src             = src;
        exe_csr_src_is_zero_reg = z;
        for (int c = 1; c <= cmax && !seen; c++) begin
            @(posedge clk);
            #1;
            exe_flush = (c == fa);
            rst       = (c == ra);
            if (!ed && c == kill) exe_csr_valid = 1'b0;
            if (csr_done) begin
                seen = 1'b1;
                lat  = c;
            end
            if (ed) begin
                chk({nm, "_stall"}, 64'(csr_stall), 64'(c < elat));
            end else if (c == kill + 1) begin
                chk({nm, "_quiet"},
                    {core_csr_addr, core_csr_wdata, core_csr_write, csr_stall,
                     csr_done, csr_rd_we, csr_illegal, 13'd0},
                    64'd0);
                chk({nm, "_quiet_rd"}, 64'(csr_rd_wdata), 64'd0);
            end
        end
        if (ed) begin
            chk({nm, "_latency"}, 64'(lat), 64'(elat));
            @(posedge clk);
            #1;
            exe_csr_valid = 1'b0;
            exe_flush     = 1'b0;
        end else begin
            chk({nm, "_no_done"}, 64'(seen), 64'd0);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {core_csr_addr, core_csr_wdata, core_csr_write, csr_stall,
             csr_done, csr_rd_we, csr_illegal, 13'd0},
            64'd0);
        chk("reset_rd", 64'(csr_rd_wdata), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("rw", 2'b01, 12'h340, 32'hDEADBEEF, 1'b0, 32'h12345678, 0, 0,
            1, 32'hDEADBEEF, 1, 32'h12345678, 1'b1, 1'b0, 3);
        run("rs", 2'b10, 12'h300, 32'h000000F0, 1'b0, 32'h0000000F, 0, 0,
            1, 32'h000000FF, 1, 32'h0000000F, 1'b1, 1'b0, 3);
        run("rs_x0", 2'b10, 12'h300, 32'h00000000, 1'b1, 32'h0000000F, 0, 0,
            0, 32'h0, 1, 32'h0000000F, 1'b1, 1'b0, 2);
        run("rc", 2'b11, 12'h344, 32'h00000003, 1'b0, 32'hFFFFFFFF, 0, 0,
            1, 32'hFFFFFFFC, 1, 32'hFFFFFFFF, 1'b1, 1'b0, 3);
        run("flush_read", 2'b01, 12'h341, 32'h11112222, 1'b0, 32'h00000100, 1, 0,
            0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 0);
        run("flush_write", 2'b01, 12'h341, 32'h80000004, 1'b0, 32'h00000100, 2, 0,
            1, 32'h80000004, 1, 32'h00000100, 1'b1, 1'b0, 3);
        run("flush_done", 2'b10, 12'h305, 32'h00000001, 1'b0, 32'h00000200, 3, 0,
            1, 32'h00000201, 1, 32'h00000200, 1'b0, 1'b0, 3);
        run("op00", 2'b00, 12'h340, 32'hFFFF0000, 1'b0, 32'h000055AA, 0, 0,
            0, 32'h0, 1, 32'h000055AA, 1'b0, 1'b1, 2);
`ifdef NANORV32_CSR_RO_CHECK_EN
        run("ro_rw", 2'b01, 12'hC00, 32'h00000001, 1'b0, 32'h00001000, 0, 0,
            0, 32'h0, 1, 32'h00001000, 1'b0, 1'b1, 2);
        run("ro_rc", 2'b11, 12'hC01, 32'h0000000F, 1'b0, 32'h000000FF, 0, 0,
            0, 32'h0, 1, 32'h000000FF, 1'b0, 1'b1, 2);
`else
        run("ro_rw", 2'b01, 12'hC00, 32'h00000001, 1'b0, 32'h00001000, 0, 0,
            1, 32'h00000001, 1, 32'h00001000, 1'b1, 1'b0, 3);
        run("ro_rc", 2'b11, 12'hC01, 32'h0000000F, 1'b0, 32'h000000FF, 0, 0,
            1, 32'h000000F0, 1, 32'h000000FF, 1'b1, 1'b0, 3);
`endif
        run("ro_rs_x0", 2'b10, 12'hC02, 32'h00000000, 1'b1, 32'h00000077, 0, 0,
            0, 32'h0, 1, 32'h00000077, 1'b1, 1'b0, 2);
        run("rst_write", 2'b01, 12'h340, 32'hA5A5A5A5, 1'b0, 32'h0BADF00D, 0, 2,
            1, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 1'b0, 0);
        run("after_rst", 2'b11, 12'h344, 32'hF0000000, 1'b0, 32'h12345678, 0, 0,
            1, 32'h02345678, 1, 32'h12345678, 1'b1, 1'b0, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("write_queue_left", 64'(wq.size()), 64'd0);
        chk("done_queue_left", 64'(dq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
